axis_m_burst: RTL and testbench

- Parametrised successor to the single-word AXI-Stream master.
- Buffers words from a local write port in an internal FIFO.
- On a start command, streams a programmable-length burst of beats on an AXI4-Stream master interface, asserting tlast on the final beat.
- Sits between a producer (CPU/DMA-side register logic) and any AXI-Stream slave.

---
 rtl/axis_m_burst.sv | 118 +++++++++++
 tb/tb_axis_m_burst.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_m_burst.sv
// Buffered AXI4-Stream burst master: words are queued through a local write port
// and a start command streams a programmable number of them, with tlast on the final beat.
module axis_m_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          burst_len,
  output logic                          busy,
  input  logic                          tready,
  output logic                          tvalid,
  output logic [DATA_WIDTH-1:0]         tdata,
  output logic                          tlast,
  output logic                          finish
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       count_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic push;
  logic pop;

  assign push   = wr_en && !full;
  assign pop    = tvalid && tready;
  assign full   = (count_q == LVL_W'(FIFO_DEPTH));
  assign level  = count_q;
  assign busy   = (state_q != IDLE);
  assign finish = (state_q == DONE);

  // Outputs come straight from flops only, so tvalid never sees tready combinationally
  // and stays put until a handshake drains the head word.
  assign tvalid = (state_q == STREAM) && (count_q != '0);
  assign tlast  = tvalid && (remaining_q == LEN_WIDTH'(1));
  assign tdata  = tvalid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          remaining_d = burst_len;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (pop) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_m_burst.sv
// Randomised scoreboard bench for axis_m_burst: a queue-based model predicts the beat
// stream and a negedge monitor checks every handshake, hold-stability and finish pulse.
module tb_axis_m_burst;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic [3:0]    level;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          tready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          finish;

  axis_m_burst #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .tready    (tready),
    .tvalid    (tvalid),
    .tdata     (tdata),
    .tlast     (tlast),
    .finish    (finish)
  );

  always #5 aclk = ~aclk;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] dataQ[$];
  bit            lastQ[$];
  int            startsIssued = 0;
  int            burstsFinished = 0;
  int            burstsAbandoned = 0;
  int            beatsSeen = 0;
  bit            finishPending = 0;
  bit            prevStall = 0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;

  function automatic bit modelActive();
    return startsIssued != (burstsFinished + burstsAbandoned);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Registered-state predictions, taken just after the clock edge.
  task automatic checkOutput();
    bit expValid;
    expValid = modelActive() && (lastQ.size() != 0) && (dataQ.size() != 0);
    checkVal("tvalid", 32'(tvalid), 32'(expValid));
    if (expValid) begin
      checkVal("tdata", tdata, dataQ[0]);
      checkVal("tlast", 32'(tlast), 32'(lastQ[0]));
    end else begin
      checkVal("tlastIdle", 32'(tlast), 32'(0));
    end
    checkVal("busy", 32'(busy), 32'(modelActive()));
    checkVal("level", 32'(level), 32'(dataQ.size()));
    checkVal("full", 32'(full), 32'(dataQ.size() == DEPTH));
  endtask

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic st,
                               input logic [LW-1:0] len, input logic rdy);
    wr_en     = wr;
    wr_data   = d;
    start     = st;
    burst_len = len;
    tready    = rdy;
    if (wr && dataQ.size() < DEPTH) dataQ.push_back(d);
    if (st && len != 0 && !modelActive()) begin
      startsIssued++;
      for (int i = 0; i < int'(len); i++) lastQ.push_back(i == int'(len) - 1);
    end
  endtask

  task automatic tick(input logic wr, input logic [DW-1:0] d, input logic st,
                      input logic [LW-1:0] len, input logic rdy);
    @(posedge aclk);
    #1;
    checkOutput();
    applyStimulus(wr, d, st, len, rdy);
  endtask

  // Called just after a clock edge (or at time zero); reset takes effect immediately.
  task automatic applyReset();
    areset    = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    start     = 1'b0;
    burst_len = '0;
    tready    = 1'b0;
    #1;
    checkVal("rstTvalid", 32'(tvalid), 32'(0));
    checkVal("rstTlast", 32'(tlast), 32'(0));
    checkVal("rstTdata", tdata, 32'(0));
    checkVal("rstLevel", 32'(level), 32'(0));
    checkVal("rstFull", 32'(full), 32'(0));
    checkVal("rstBusy", 32'(busy), 32'(0));
    checkVal("rstFinish", 32'(finish), 32'(0));
    dataQ.delete();
    lastQ.delete();
    burstsAbandoned = startsIssued - burstsFinished;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic waitIdle(input int mode, input bit feed, input int budget);
    int n;
    logic rdy;
    n = 0;
    while (modelActive() && n < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      tick(feed && ($urandom_range(0, 1) == 1), $urandom, 1'b0, '0, rdy);
      n++;
    end
    if (modelActive()) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL burstTimeout: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        finishPending = 0;
        prevStall     = 0;
      end else begin
        checkVal("finish", 32'(finish), 32'(finishPending));
        if (finishPending) begin
          finishPending = 0;
          burstsFinished++;
        end
        if (prevStall) begin
          checkVal("holdValid", 32'(tvalid), 32'(1));
          checkVal("holdData", tdata, prevData);
          checkVal("holdLast", 32'(tlast), 32'(prevLast));
        end
        if (tvalid && tready) begin
          if (dataQ.size() == 0 || lastQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedBeat: got data %h, expected no beat", tdata);
          end else begin
            bit expLast;
            expLast = lastQ.pop_front();
            checkVal("beatData", tdata, dataQ.pop_front());
            checkVal("beatLast", 32'(tlast), 32'(expLast));
            beatsSeen++;
            if (expLast) finishPending = 1;
          end
        end
        prevStall = tvalid && !tready;
        prevData  = tdata;
        prevLast  = tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;

    applyReset();

    // Two-word burst with tlast on the second word
    tick(1'b1, 32'hAAAABBBB, 1'b0, '0, 1'b1);
    tick(1'b1, 32'hCCCCDDDD, 1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1, 8'd2, 1'b1);
    waitIdle(0, 1'b0, 20);
    tick(1'b0, '0, 1'b0, '0, 1'b1);

    // Backpressure with ready pattern 1,0,0
    for (int i = 0; i < 4; i++) tick(1'b1, $urandom, 1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1, 8'd4, 1'b0);
    waitIdle(1, 1'b0, 40);

    // Fill to full, drop the ninth word, then drain all eight
    for (int i = 0; i < 9; i++) tick(1'b1, 32'h9000_0000 + i, 1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1, 8'd8, 1'b1);
    waitIdle(0, 1'b0, 30);

    // Burst longer than the buffered data stalls until more arrives
    tick(1'b1, 32'h4444_0001, 1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1, 8'd3, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0, '0, 1'b1);
    tick(1'b1, 32'h4444_0002, 1'b0, '0, 1'b1);
    tick(1'b1, 32'h4444_0003, 1'b0, '0, 1'b1);
    waitIdle(0, 1'b0, 20);

    // Zero-length start and a start while busy are both ignored
    tick(1'b0, '0, 1'b1, 8'd0, 1'b1);
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, '0, 1'b0);
    base = beatsSeen;
    tick(1'b0, '0, 1'b1, 8'd3, 1'b0);
    tick(1'b0, '0, 1'b1, 8'd5, 1'b1);
    waitIdle(0, 1'b0, 20);
    checkVal("ignoredStartBeats", 32'(beatsSeen - base), 32'(3));
    for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b0, '0, 1'b1);
    waitIdle(0, 1'b0, 20);

    // Reset after two of five beats, then a clean burst of fresh data
    applyReset();
    for (int i = 0; i < 5; i++) tick(1'b1, 32'h6600_0000 + i, 1'b0, '0, 1'b0);
    base = beatsSeen;
    tick(1'b0, '0, 1'b1, 8'd5, 1'b1);
    n = 0;
    while ((beatsSeen - base) < 2 && n < 50) begin
      tick(1'b0, '0, 1'b0, '0, 1'b1);
      n++;
    end
    applyReset();
    tick(1'b1, 32'h7700_0001, 1'b0, '0, 1'b0);
    tick(1'b1, 32'h7700_0002, 1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1, 8'd2, 1'b1);
    waitIdle(0, 1'b0, 20);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0,
           LW'($urandom_range(0, 12)), $urandom_range(0, 3) != 0);
    end
    waitIdle(2, 1'b1, 500);
    tick(1'b0, '0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
